// File: rtl/ahb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// ahb_bus_arbiter
//   Round-robin arbiter that shares the single AHB-lite slave port of the
//   AHB-to-APB bridge between NUM_M masters. Produces a registered one-hot
//   grant, the address-phase owner index (HADDR/HTRANS/HWRITE mux select) and
//   the data-phase owner index (HWDATA mux select).
//
// Ports
//   HCLK       in   1      bus clock
//   HRESETn    in   1      asynchronous active-low reset
//   HBUSREQ    in   NUM_M  per-master bus request
//   HLOCK      in   NUM_M  per-master locked-sequence request
//   HTRANS     in   2      muxed HTRANS of the address-phase owner
//   HREADY     in   1      bridge HREADYout, transfer completes when 1
//   HGRANT     out  NUM_M  one-hot grant
//   HMASTER    out  2      address-phase owner index
//   HMASTER_D  out  2      data-phase owner index
//   HMASTLOCK  out  1      current address phase belongs to a locked sequence
// ---------------------------------------------------------------------------
module ahb_bus_arbiter #(
  parameter int NUM_M     = 4,
  parameter int DEF_M     = 0,
  parameter int MAX_BEATS = 8
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic [NUM_M-1:0] HBUSREQ,
  input  logic [NUM_M-1:0] HLOCK,
  input  logic [1:0]       HTRANS,
  input  logic             HREADY,
  output logic [NUM_M-1:0] HGRANT,
  output logic [1:0]       HMASTER,
  output logic [1:0]       HMASTER_D,
  output logic             HMASTLOCK
);

  typedef enum logic [1:0] {
    ST_PARK     = 2'b00,
    ST_OWN      = 2'b01,
    ST_LOCKED   = 2'b10,
    ST_HANDOVER = 2'b11
  } state_t;

  localparam logic [1:0]       DEF_IDX   = 2'(DEF_M);
  localparam logic [3:0]       BEAT_MAX  = 4'(MAX_BEATS);
  localparam logic [NUM_M-1:0] DEF_GRANT = NUM_M'(1) << DEF_M;

  // Beat counter increment that sticks at MAX_BEATS instead of wrapping.
  function automatic logic [3:0] beat_sat(input logic [3:0] cnt, input logic inc);
    if (inc && (cnt < BEAT_MAX)) begin
      return cnt + 4'd1;
    end
    return cnt;
  endfunction

  // Round-robin pick: scan ptr+1 .. ptr+NUM_M so the current owner comes
  // last. Iterating from the far end lets the nearest requester win.
  function automatic logic [1:0] rr_pick(input logic [NUM_M-1:0] req,
                                         input logic [1:0]       ptr);
    logic [1:0] pick;
    logic [1:0] idx;
    pick = DEF_IDX;
    for (int k = NUM_M; k >= 1; k--) begin
      idx = 2'((int'(ptr) + k) % NUM_M);
      if (req[idx]) begin
        pick = idx;
      end
    end
    return pick;
  endfunction

  state_t           r_state;
  state_t           w_state_nxt;
  logic [NUM_M-1:0] r_grant;
  logic [1:0]       r_master;
  logic [1:0]       r_master_d;
  logic             r_mastlock;
  logic [3:0]       r_cnt;

  logic             w_beat;
  logic             w_own_req;
  logic             w_own_lock;
  logic             w_others_req;
  logic             w_idle;
  logic [3:0]       w_cnt_inc;
  logic [1:0]       w_winner;
  logic             w_arb_allow;
  logic             w_arb_cond;
  logic             w_arb;

  // The RR pointer is the last owner, which is always r_master.
  assign w_beat       = HREADY & HTRANS[1];
  assign w_own_req    = HBUSREQ[r_master];
  assign w_own_lock   = HLOCK[r_master];
  assign w_others_req = |(HBUSREQ & ~r_grant);
  assign w_idle       = (HTRANS == 2'b00);
  assign w_cnt_inc    = beat_sat(r_cnt, w_beat);
  assign w_winner     = rr_pick(HBUSREQ, r_master);

  // Count includes the beat completing on this edge, so an owner gets
  // exactly MAX_BEATS beats before yielding to a waiting master.
  assign w_arb_cond = !w_own_req
                    || (w_idle && w_others_req)
                    || ((w_cnt_inc == BEAT_MAX) && w_others_req && !w_own_lock);

  // Only a real change of owner counts as arbitration; this keeps the
  // parked master from cycling through HANDOVER while the bus is idle.
  assign w_arb = HREADY && w_arb_allow && w_arb_cond && (w_winner != r_master);

  // FSM state register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state <= ST_PARK;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state
  always_comb begin
    w_state_nxt = r_state;
    if (HREADY) begin
      if (w_arb) begin
        w_state_nxt = ST_HANDOVER;
      end else if ((r_state == ST_LOCKED) && w_own_lock) begin
        w_state_nxt = ST_LOCKED;
      end else if (w_own_req && w_own_lock) begin
        w_state_nxt = ST_LOCKED;
      end else if (w_own_req) begin
        w_state_nxt = ST_OWN;
      end else if (r_master == DEF_IDX) begin
        w_state_nxt = ST_PARK;
      end else begin
        w_state_nxt = ST_OWN;
      end
    end
  end

  // FSM outputs: HANDOVER blocks arbitration so the new owner gets at least
  // its first address phase; LOCKED blocks it until the owner drops HLOCK,
  // and the drop edge itself may already hand the bus over.
  always_comb begin
    w_arb_allow = 1'b0;
    case (r_state)
      ST_PARK, ST_OWN: w_arb_allow = 1'b1;
      ST_LOCKED:       w_arb_allow = !w_own_lock;
      default:         w_arb_allow = 1'b0;
    endcase
  end

  // Grant, owner indices, lock flag and beat counter all freeze on wait states.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_grant    <= DEF_GRANT;
      r_master   <= DEF_IDX;
      r_master_d <= DEF_IDX;
      r_mastlock <= 1'b0;
      r_cnt      <= 4'd0;
    end else if (HREADY) begin
      r_master_d <= r_master;
      if (w_arb) begin
        r_grant    <= NUM_M'(1) << w_winner;
        r_master   <= w_winner;
        r_mastlock <= HLOCK[w_winner];
        r_cnt      <= 4'd0;
      end else begin
        r_mastlock <= (w_state_nxt == ST_LOCKED);
        r_cnt      <= w_cnt_inc;
      end
    end
  end

  assign HGRANT    = r_grant;
  assign HMASTER   = r_master;
  assign HMASTER_D = r_master_d;
  assign HMASTLOCK = r_mastlock;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ahb_bus_arbiter
//   Directed bench for ahb_bus_arbiter (NUM_M=4, DEF_M=0, MAX_BEATS=8).
//   A table of {inputs, expected outputs} records covers request ordering,
//   release, the beat limit and wait-state freezing; hand-written sequences
//   cover reset, the locked sequence and reset asserted mid-burst.
// ---------------------------------------------------------------------------
module tb_ahb_bus_arbiter;

  logic       HCLK    = 1'b0;
  logic       HRESETn = 1'b0;
  logic [3:0] HBUSREQ = 4'b0000;
  logic [3:0] HLOCK   = 4'b0000;
  logic [1:0] HTRANS  = 2'b00;
  logic       HREADY  = 1'b1;
  logic [3:0] HGRANT;
  logic [1:0] HMASTER;
  logic [1:0] HMASTER_D;
  logic       HMASTLOCK;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    string      name;
    logic [3:0] req;
    logic [3:0] lock;
    logic [1:0] trans;
    logic       rdy;
    logic [3:0] g;
    logic [1:0] m;
    logic [1:0] md;
    logic       l;
  } vec_t;

  vec_t tbl[$];

  ahb_bus_arbiter #(
    .NUM_M    (4),
    .DEF_M    (0),
    .MAX_BEATS(8)
  ) dut (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .HBUSREQ  (HBUSREQ),
    .HLOCK    (HLOCK),
    .HTRANS   (HTRANS),
    .HREADY   (HREADY),
    .HGRANT   (HGRANT),
    .HMASTER  (HMASTER),
    .HMASTER_D(HMASTER_D),
    .HMASTLOCK(HMASTLOCK)
  );

  always #5 HCLK = ~HCLK;

  task automatic add(input string name, input logic [3:0] req, input logic [3:0] lock,
                     input logic [1:0] trans, input logic rdy, input logic [3:0] g,
                     input logic [1:0] m, input logic [1:0] md, input logic l);
    vec_t v;
    v.name = name; v.req = req; v.lock = lock; v.trans = trans; v.rdy = rdy;
    v.g = g; v.m = m; v.md = md; v.l = l;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [3:0] g, input logic [1:0] m,
                       input logic [1:0] md, input logic l);
    n_vec++;
    if (HGRANT !== g || HMASTER !== m || HMASTER_D !== md || HMASTLOCK !== l) begin
      n_bad++;
      $display("FAIL %s: got grant=%b master=%0d master_d=%0d lock=%b, want grant=%b master=%0d master_d=%0d lock=%b",
               name, HGRANT, HMASTER, HMASTER_D, HMASTLOCK, g, m, md, l);
    end
  endtask

  task automatic step(input string name, input logic [3:0] req, input logic [3:0] lock,
                      input logic [1:0] trans, input logic rdy, input logic [3:0] g,
                      input logic [1:0] m, input logic [1:0] md, input logic l);
    HBUSREQ = req; HLOCK = lock; HTRANS = trans; HREADY = rdy;
    @(posedge HCLK);
    #1;
    check(name, g, m, md, l);
  endtask

  initial begin
    // Table: starts from M0 parked, beat counter 0.
    add("m1_wins_rr",     4'b0110, 4'b0000, 2'b00, 1'b1, 4'b0010, 2'd1, 2'd0, 1'b0);
    add("m1_handover",    4'b0110, 4'b0000, 2'b10, 1'b1, 4'b0010, 2'd1, 2'd1, 1'b0);
    add("m1_release",     4'b0100, 4'b0000, 2'b00, 1'b1, 4'b0100, 2'd2, 2'd1, 1'b0);
    add("m2_data_phase",  4'b0100, 4'b0000, 2'b10, 1'b1, 4'b0100, 2'd2, 2'd2, 1'b0);
    add("m2_release_m1",  4'b0010, 4'b0000, 2'b00, 1'b1, 4'b0010, 2'd1, 2'd2, 1'b0);
    add("m1_beat1",       4'b1010, 4'b0000, 2'b10, 1'b1, 4'b0010, 2'd1, 2'd1, 1'b0);
    for (int i = 2; i <= 7; i++)
      add($sformatf("m1_beat%0d", i), 4'b1010, 4'b0000, 2'b11, 1'b1, 4'b0010, 2'd1, 2'd1, 1'b0);
    add("m1_beat8_to_m3", 4'b1010, 4'b0000, 2'b11, 1'b1, 4'b1000, 2'd3, 2'd1, 1'b0);
    for (int i = 0; i < 3; i++)
      add($sformatf("wait_hold%0d", i), 4'b1000, 4'b0000, 2'b10, 1'b0, 4'b1000, 2'd3, 2'd1, 1'b0);
    add("wait_release",   4'b1000, 4'b0000, 2'b10, 1'b1, 4'b1000, 2'd3, 2'd3, 1'b0);
    for (int i = 0; i < 3; i++)
      add($sformatf("arb_frozen%0d", i), 4'b0001, 4'b0000, 2'b00, 1'b0, 4'b1000, 2'd3, 2'd3, 1'b0);
    add("arb_on_ready",   4'b0001, 4'b0000, 2'b00, 1'b1, 4'b0001, 2'd0, 2'd3, 1'b0);
    add("m0_data_phase",  4'b0001, 4'b0000, 2'b10, 1'b1, 4'b0001, 2'd0, 2'd0, 1'b0);
    add("m0_idle_alone",  4'b0001, 4'b0000, 2'b00, 1'b1, 4'b0001, 2'd0, 2'd0, 1'b0);
    add("park_no_req",    4'b0000, 4'b0000, 2'b00, 1'b1, 4'b0001, 2'd0, 2'd0, 1'b0);

    // Reset values while held, then 10 idle cycles parked on M0.
    @(posedge HCLK); #1;
    check("reset_held", 4'b0001, 2'd0, 2'd0, 1'b0);
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    for (int i = 0; i < 10; i++)
      step($sformatf("idle_park%0d", i), 4'b0000, 4'b0000, 2'b00, 1'b1, 4'b0001, 2'd0, 2'd0, 1'b0);

    foreach (tbl[i])
      step(tbl[i].name, tbl[i].req, tbl[i].lock, tbl[i].trans, tbl[i].rdy,
           tbl[i].g, tbl[i].m, tbl[i].md, tbl[i].l);

    // Locked sequence: M2 grabs the bus locked and keeps it despite 20 beats
    // with everyone requesting; dropping HLOCK hands over to M3 at once.
    step("lock_grant_m2", 4'b0100, 4'b0100, 2'b00, 1'b1, 4'b0100, 2'd2, 2'd0, 1'b1);
    step("lock_enter",    4'b1111, 4'b0100, 2'b10, 1'b1, 4'b0100, 2'd2, 2'd2, 1'b1);
    for (int i = 0; i < 20; i++)
      step($sformatf("lock_hold%0d", i), 4'b1111, 4'b0100, 2'b11, 1'b1, 4'b0100, 2'd2, 2'd2, 1'b1);
    step("lock_drop_m3",  4'b1111, 4'b0000, 2'b11, 1'b1, 4'b1000, 2'd3, 2'd2, 1'b0);

    // M3 bursts alone up to five beats, then reset lands mid-cycle.
    step("m3_beat1", 4'b1000, 4'b0000, 2'b10, 1'b1, 4'b1000, 2'd3, 2'd3, 1'b0);
    for (int i = 2; i <= 5; i++)
      step($sformatf("m3_beat%0d", i), 4'b1000, 4'b0000, 2'b11, 1'b1, 4'b1000, 2'd3, 2'd3, 1'b0);
    n_vec++;
    if (dut.r_cnt !== 4'd5) begin
      n_bad++;
      $display("FAIL beat_count_pre_reset: got %0d, want 5", dut.r_cnt);
    end
    #2;
    HRESETn = 1'b0;
    #1;
    check("async_reset_mid_burst", 4'b0001, 2'd0, 2'd0, 1'b0);
    n_vec++;
    if (dut.r_cnt !== 4'd0) begin
      n_bad++;
      $display("FAIL beat_count_reset: got %0d, want 0", dut.r_cnt);
    end
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    step("after_reset_park", 4'b0000, 4'b0000, 2'b00, 1'b1, 4'b0001, 2'd0, 2'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
